secure_reg_access_ctrl: RTL and testbench

//  Round-robin arbiter + access sequencer that shares one bank of secure registers between NUM_REQ requesters.

---
 rtl/secure_reg_pkg.sv | 22 ++
 rtl/secure_reg_access_ctrl_rr_arbiter.sv | 33 +++
 rtl/secure_reg_access_ctrl.sv | 165 ++++++++++++++++
 tb/tb_secure_reg_access_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/secure_reg_pkg.sv
// Shared types and constants for the secure register access controller.
// Latency: none (declarations only).
// Backpressure: not applicable.
package secure_reg_pkg;

  // Access sequencer states: one transaction in flight at a time
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  // The only thread id allowed to touch the bank
  localparam int PRIV_TID = 0;

  // Highest register address; writing 1 here sets the sticky lock when built with the lock feature
  function automatic int lock_addr(input int addr_width);
    return (1 << addr_width) - 1;
  endfunction

endpackage

// File: rtl/secure_reg_access_ctrl_rr_arbiter.sv
// Round-robin pick: first set request at or after i_rr_ptr, wrapping to 0.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the grant is honoured.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDW-1:0]     i_rr_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDW-1:0]     o_idx,
  output logic               o_any
);

  logic [IDW-1:0] w_cand;

  // Walk the candidates starting at the pointer and keep the first one requesting
  always_comb begin
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    w_cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = IDW'((int'(i_rr_ptr) + k) % NUM_REQ);
      if (!o_any && i_req[w_cand]) begin
        o_any         = 1'b1;
        o_idx         = w_cand;
        o_gnt[w_cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/secure_reg_access_ctrl.sv
// Round-robin arbiter + access sequencer sharing one secure register bank; only thread 0 reaches the bank.
// Latency: allowed access gnt->resp_valid 3 cycles, denied access 1 cycle; one transaction in flight.
// Backpressure: requesters hold req until gnt; no grant is issued outside IDLE. Optional lock: SECURE_REG_LOCK_EN.
module secure_reg_access_ctrl
  import secure_reg_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 3,
  parameter  int TID_WIDTH  = 2,
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*TID_WIDTH-1:0]  req_tid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          resp_valid,
  output logic [IDW-1:0]                resp_id,
  output logic                          resp_err,
  output logic [DATA_WIDTH-1:0]         resp_rdata,
  output logic                          reg_access_en,
  output logic                          reg_wr_en,
  output logic [ADDR_WIDTH-1:0]         reg_addr,
  output logic [DATA_WIDTH-1:0]         reg_wdata,
  output logic [TID_WIDTH-1:0]          reg_tid,
  input  logic [DATA_WIDTH-1:0]         reg_rdata
`ifdef SECURE_REG_LOCK_EN
  ,
  output logic                          locked
`endif
);

  state_t                r_state, w_next;
  logic [IDW-1:0]        r_rr_ptr, r_id;
  logic                  r_we, r_err;
  logic [TID_WIDTH-1:0]  r_tid;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata, r_rdata;

  logic [NUM_REQ-1:0]    w_gnt;
  logic [IDW-1:0]        w_idx;
  logic                  w_any, w_start, w_deny;

  logic [TID_WIDTH-1:0]  w_tid_a   [NUM_REQ];
  logic [ADDR_WIDTH-1:0] w_addr_a  [NUM_REQ];
  logic [DATA_WIDTH-1:0] w_wdata_a [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_tid_a[gi]   = req_tid[gi*TID_WIDTH +: TID_WIDTH];
    assign w_addr_a[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
    assign w_wdata_a[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDW(IDW)) u_arb (
    .i_req    (req),
    .i_rr_ptr (r_rr_ptr),
    .o_gnt    (w_gnt),
    .o_idx    (w_idx),
    .o_any    (w_any)
  );

  // A grant is taken only when idle and something is requesting
  assign w_start = (r_state == IDLE) && w_any;

`ifdef SECURE_REG_LOCK_EN
  localparam logic [ADDR_WIDTH-1:0] LOCK_A = ADDR_WIDTH'(lock_addr(ADDR_WIDTH));
  logic r_locked;

  // Sticky lock: set when an allowed write of bit0=1 reaches the lock address; only reset clears it
  always_ff @(posedge clk) begin
    if (rst) begin
      r_locked <= 1'b0;
    end else if (r_state == ISSUE && r_we && r_addr == LOCK_A && r_wdata[0]) begin
      r_locked <= 1'b1;
    end
  end

  assign locked = r_locked;
  assign w_deny = (w_tid_a[w_idx] != TID_WIDTH'(PRIV_TID)) || (r_locked && req_we[w_idx]);
`else
  assign w_deny = (w_tid_a[w_idx] != TID_WIDTH'(PRIV_TID));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Capture the granted request, advance the pointer, and latch bank read data in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_id     <= '0;
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_tid    <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_start) begin
        r_id     <= w_idx;
        r_we     <= req_we[w_idx];
        r_tid    <= w_tid_a[w_idx];
        r_addr   <= w_addr_a[w_idx];
        r_wdata  <= w_wdata_a[w_idx];
        r_err    <= w_deny;
        r_rdata  <= '0;
        r_rr_ptr <= (w_idx == IDW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
      end
      if (r_state == WAIT) begin
        r_rdata <= r_we ? '0 : reg_rdata;
      end
    end
  end

  // Next state and state-decoded outputs; every output idles at 0
  always_comb begin
    w_next        = r_state;
    gnt           = '0;
    resp_valid    = 1'b0;
    resp_id       = '0;
    resp_err      = 1'b0;
    resp_rdata    = '0;
    reg_access_en = 1'b0;
    reg_wr_en     = 1'b0;
    reg_addr      = '0;
    reg_wdata     = '0;
    reg_tid       = '0;
    case (r_state)
      IDLE: begin
        if (!rst) gnt = w_gnt;
        if (w_any) w_next = w_deny ? RESP : ISSUE;
      end
      ISSUE: begin
        reg_access_en = 1'b1;
        reg_wr_en     = r_we;
        reg_addr      = r_addr;
        reg_wdata     = r_wdata;
        reg_tid       = r_tid;
        w_next        = WAIT;
      end
      WAIT: begin
        w_next = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_id    = r_id;
        resp_err   = r_err;
        resp_rdata = r_rdata;
        w_next     = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_secure_reg_access_ctrl.sv
// Self-checking bench for secure_reg_access_ctrl with a behavioural register bank.
// Latency: bank returns read data one cycle after the strobe.
// Backpressure: requesters hold req until they see gnt.
module tb_secure_reg_access_ctrl;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int TW = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req, req_we;
  logic [N*TW-1:0] req_tid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    gnt;
  logic            resp_valid, resp_err;
  logic [1:0]      resp_id;
  logic [DW-1:0]   resp_rdata;
  logic            reg_access_en, reg_wr_en;
  logic [AW-1:0]   reg_addr;
  logic [DW-1:0]   reg_wdata;
  logic [TW-1:0]   reg_tid;
  logic [DW-1:0]   reg_rdata;
`ifdef SECURE_REG_LOCK_EN
  logic            locked;
`endif

  secure_reg_access_ctrl #(.NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TID_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_tid(req_tid),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt),
    .resp_valid(resp_valid), .resp_id(resp_id), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .reg_access_en(reg_access_en), .reg_wr_en(reg_wr_en), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_tid(reg_tid), .reg_rdata(reg_rdata)
`ifdef SECURE_REG_LOCK_EN
    , .locked(locked)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int strobe_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Behavioural bank: registered read data, initial contents A5A5_000<addr>
  logic [DW-1:0] bank [8];
  logic [DW-1:0] bank_rd = '0;
  bit            bank_ready = 1'b0;
  assign reg_rdata = bank_rd;

  always @(posedge clk) begin
    if (!bank_ready) begin
      for (int i = 0; i < 8; i++) bank[i] <= 32'hA5A5_0000 | i;
      bank_ready <= 1'b1;
    end else if (reg_access_en) begin
      if (reg_wr_en) bank[reg_addr] <= reg_wdata;
      else           bank_rd <= bank[reg_addr];
    end
  end

  // Every cycle: bank side quiet when not strobed, grant at most one-hot
  always @(negedge clk) begin
    if (reg_access_en) strobe_cnt++;
    else chk("reg_idle_zero", reg_wdata | 32'({reg_wr_en, reg_addr, reg_tid}), 32'd0);
    chk("gnt_onehot0", 32'($onehot0(gnt)), 32'd1);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input int r, input logic we, input logic [1:0] tid,
                         input logic [2:0] a, input logic [31:0] wd);
    req[r]              = 1'b1;
    req_we[r]           = we;
    req_tid[r*TW +: TW] = tid;
    req_addr[r*AW +: AW] = a;
    req_wdata[r*DW +: DW] = wd;
  endtask

  // Single isolated request: check grant, latency, response fields and bank strobe count
  task automatic run_one(input string nm, input int r, input logic we, input logic [1:0] tid,
                         input logic [2:0] a, input logic [31:0] wd, input logic e_err,
                         input logic [31:0] e_rd, input int e_lat);
    int s0, lat;
    bit got;
    s0 = strobe_cnt;
    set_req(r, we, tid, a, wd);
    got = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) begin got = 1'b1; break; end
    end
    chk({nm, "_gnt"}, 32'(gnt), 32'(1 << r));
    @(posedge clk); #1 req = '0;
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (resp_valid) begin lat = k; break; end
    end
    chk({nm, "_lat"}, 32'(lat), 32'(e_lat));
    chk({nm, "_id"}, 32'(resp_id), 32'(r));
    chk({nm, "_err"}, 32'(resp_err), 32'(e_err));
    chk({nm, "_rdata"}, resp_rdata, e_rd);
    @(posedge clk); #1;
    chk({nm, "_strobes"}, 32'(strobe_cnt - s0), e_err ? 32'd0 : 32'd1);
  endtask

  typedef struct {
    int          r;
    logic        we;
    logic [1:0]  tid;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic        e_err;
    logic [31:0] e_rd;
    int          e_lat;
  } vec_t;

  vec_t tbl [12];

  logic [31:0] m_mem [8];
  bit          m_locked;
  int          m_ptr, last_resp, g, e_id, ng;
  logic        e_err, deny, f_we;
  logic [1:0]  f_tid;
  logic [2:0]  f_a;
  logic [31:0] f_wd, e_rd, v2;
  logic [N-1:0] exp_g;
  logic [N-1:0] rr_got [5];
  logic [N-1:0] rr_exp [5];

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_tid = '0; req_addr = '0; req_wdata = '0;
    tbl[0]  = '{0, 1'b0, 2'd0, 3'd2, 32'h0,         1'b0, 32'hA5A5_0002, 3};
    tbl[1]  = '{1, 1'b1, 2'd1, 3'd1, 32'h1234_5678, 1'b1, 32'h0,         1};
    tbl[2]  = '{2, 1'b0, 2'd0, 3'd1, 32'h0,         1'b0, 32'hA5A5_0001, 3};
    tbl[3]  = '{2, 1'b1, 2'd0, 3'd3, 32'hDEAD_BEEF, 1'b0, 32'h0,         3};
    tbl[4]  = '{3, 1'b0, 2'd0, 3'd3, 32'h0,         1'b0, 32'hDEAD_BEEF, 3};
    tbl[5]  = '{1, 1'b0, 2'd2, 3'd5, 32'h0,         1'b1, 32'h0,         1};
    tbl[6]  = '{2, 1'b0, 2'd3, 3'd0, 32'h0,         1'b1, 32'h0,         1};
    tbl[7]  = '{0, 1'b0, 2'd0, 3'd7, 32'h0,         1'b0, 32'hA5A5_0007, 3};
    tbl[8]  = '{3, 1'b1, 2'd0, 3'd7, 32'h5555_5554, 1'b0, 32'h0,         3};
    tbl[9]  = '{1, 1'b0, 2'd0, 3'd7, 32'h0,         1'b0, 32'h5555_5554, 3};
    tbl[10] = '{2, 1'b1, 2'd0, 3'd1, 32'hCAFE_0001, 1'b0, 32'h0,         3};
    tbl[11] = '{0, 1'b0, 2'd0, 3'd1, 32'h0,         1'b0, 32'hCAFE_0001, 3};

    // Reset state, sampled while rst is still asserted
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_resp", 32'({resp_valid, resp_id, resp_err}) | resp_rdata, 32'd0);
    chk("rst_reg", 32'({reg_access_en, reg_wr_en, reg_addr, reg_tid}) | reg_wdata, 32'd0);
`ifdef SECURE_REG_LOCK_EN
    chk("rst_locked", 32'(locked), 32'd0);
`endif
    @(posedge clk); #1 rst = 1'b0;

    // Table of isolated accesses
    for (int i = 0; i < 12; i++)
      run_one($sformatf("vec%0d", i), tbl[i].r, tbl[i].we, tbl[i].tid, tbl[i].addr,
              tbl[i].wd, tbl[i].e_err, tbl[i].e_rd, tbl[i].e_lat);

    // Round robin with all four held from rr_ptr=0
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 2'd0, 3'(i), 32'h0);
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;
    ng = 0;
    for (int k = 0; k < 60 && ng < 5; k++) begin
      @(negedge clk);
      if (gnt != '0) begin rr_got[ng] = gnt; ng++; end
      @(posedge clk); #1;
    end
    req = '0;
    chk("rr_count", 32'(ng), 32'd5);
    for (int i = 0; i < 5; i++) chk($sformatf("rr_gnt%0d", i), 32'(rr_got[i]), 32'(rr_exp[i]));
    repeat (6) @(posedge clk); #1;

    // Reset while the bank read is in WAIT: abandoned, then arbitration restarts at 0
    set_req(2, 1'b0, 2'd0, 3'd4, 32'h0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (gnt != '0) break;
    end
    chk("mid_gnt", 32'(gnt), 32'b0100);
    @(posedge clk); #1 req = '0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_resp", 32'({resp_valid, resp_id, resp_err}) | resp_rdata, 32'd0);
    chk("mid_reg", 32'({reg_access_en, reg_wr_en, reg_addr, reg_tid}) | reg_wdata, 32'd0);
    @(posedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("mid_quiet", 32'({resp_valid, reg_access_en}), 32'd0);
    end
    @(posedge clk); #1;
    set_req(1, 1'b0, 2'd0, 3'd0, 32'h0);
    set_req(3, 1'b0, 2'd0, 3'd0, 32'h0);
    @(negedge clk);
    chk("mid_regrant", 32'(gnt), 32'b0010);
    @(posedge clk); #1 req = '0;
    repeat (6) @(posedge clk); #1;

    // Randomized traffic against a transaction-level model
    do_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = bank[i];
    m_locked = 1'b0; m_ptr = 0; last_resp = -1; e_id = 0; e_err = 1'b0; e_rd = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req[i] && $urandom_range(0, 2) == 0)
          set_req(i, 1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? 2'($urandom_range(1, 3)) : 2'd0,
                  3'($urandom_range(0, 7)), $urandom);
        else if (req[i] && $urandom_range(0, 15) == 0)
          req[i] = 1'b0;
      end
      @(negedge clk);
      g = -1;
      if (c > last_resp)
        for (int k = 0; k < N; k++)
          if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      exp_g = (g >= 0) ? 4'(1 << g) : 4'b0;
      chk("rnd_gnt", 32'(gnt), 32'(exp_g));
      if (c == last_resp) begin
        chk("rnd_valid", 32'(resp_valid), 32'd1);
        chk("rnd_id", 32'(resp_id), 32'(e_id));
        chk("rnd_err", 32'(resp_err), 32'(e_err));
        chk("rnd_rdata", resp_rdata, e_rd);
      end else begin
        chk("rnd_novalid", 32'(resp_valid), 32'd0);
      end
      if (g >= 0) begin
        f_we  = req_we[g];
        f_tid = req_tid[g*TW +: TW];
        f_a   = req_addr[g*AW +: AW];
        f_wd  = req_wdata[g*DW +: DW];
        deny  = (f_tid != 2'd0);
`ifdef SECURE_REG_LOCK_EN
        deny  = deny || (m_locked && f_we);
`endif
        e_rd = '0;
        if (!deny) begin
          if (f_we) begin
            m_mem[f_a] = f_wd;
`ifdef SECURE_REG_LOCK_EN
            if (f_a == 3'd7 && f_wd[0]) m_locked = 1'b1;
`endif
          end else begin
            e_rd = m_mem[f_a];
          end
        end
        e_id = g; e_err = deny;
        last_resp = c + (deny ? 1 : 3);
        m_ptr = (g + 1) % N;
      end
      @(posedge clk); #1;
      if (g >= 0) req[g] = 1'b0;
    end
    req = '0;
    repeat (6) @(posedge clk); #1;
`ifdef SECURE_REG_LOCK_EN
    chk("rnd_locked", 32'(locked), 32'(m_locked));

    // Lock: thread-0 write of 1 to the top address locks out writes, reads still pass
    do_reset();
    @(negedge clk);
    chk("lk_rst", 32'(locked), 32'd0);
    @(posedge clk); #1;
    run_one("lk_set", 0, 1'b1, 2'd0, 3'd7, 32'h1, 1'b0, 32'h0, 3);
    chk("lk_on", 32'(locked), 32'd1);
    v2 = bank[2];
    run_one("lk_wr", 1, 1'b1, 2'd0, 3'd2, 32'h0BAD_0BAD, 1'b1, 32'h0, 1);
    chk("lk_unchanged", bank[2], v2);
    run_one("lk_rd", 2, 1'b0, 2'd0, 3'd2, 32'h0, 1'b0, v2, 3);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
